// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU request arbiter: FSM state encoding and unit select codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ALU_FUN[3:2] picks which unit's result and flag are returned
  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_CMP   = 2'b10;
  localparam logic [1:0] SEL_SHIFT = 2'b11;

endpackage

// File: rtl/alu_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, with wrap-around.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the grant is used.
// Ports: req_i (request vector), rr_ptr_i (search start), gnt_o (one-hot grant),
//        gnt_idx_o (index of gnt_o), any_req_o (at least one request set).
module rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_req_o
);

  logic             found;
  int               pos;
  logic [IDX_W-1:0] p;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    pos       = 0;
    p         = '0;
    // Scan N slots starting at the pointer; the modulo handles the wrap.
    for (int k = 0; k < N; k++) begin
      pos = (int'(rr_ptr_i) + k) % N;
      p   = IDX_W'(pos);
      if (!found && req_i[p]) begin
        found     = 1'b1;
        gnt_o[p]  = 1'b1;
        gnt_idx_o = p;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters, round-robin, returning ID-tagged results.
// Latency: accept -> resp_valid in ALU_LAT+1 cycles; back-to-back issue spacing ALU_LAT+2 cycles.
// Backpressure: resp_ready low holds RESP with stable response; no new grant until the handshake.
// Ports: CLK/RST (sync active-high); req_valid/req_ready/req_a/req_b/req_fun per-requester
//        request channel; alu_a/alu_b/alu_fun to the ALU; *_out, carry_in, *_flag from the ALU;
//        resp_valid/resp_ready/resp_data/resp_carry/resp_flag/resp_id response channel; busy.
// Optional build macro ALU_ARB_PERF_EN adds op_count and stall_count (16-bit saturating).
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ALU_LAT    = 1,
  parameter int ID_W       = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]          req_fun,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output logic [3:0]                    alu_fun,
  input  logic [DATA_WIDTH-1:0]         arith_out,
  input  logic [DATA_WIDTH-1:0]         logic_out,
  input  logic [DATA_WIDTH-1:0]         cmp_out,
  input  logic [DATA_WIDTH-1:0]         shift_out,
  input  logic                          carry_in,
  input  logic                          arith_flag,
  input  logic                          logic_flag,
  input  logic                          cmp_flag,
  input  logic                          shift_flag,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_carry,
  output logic                          resp_flag,
  output logic [ID_W-1:0]               resp_id,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]                   op_count,
  output logic [15:0]                   stall_count,
`endif
  output logic                          busy
);

  localparam int CNT_W    = 2;  // enough for ALU_LAT up to 3
  localparam int ID_W_CHK = $clog2(NUM_REQ);

  if (ID_W != ID_W_CHK) begin : g_id_w_check
    $error("alu_req_arbiter: ID_W must equal clog2(NUM_REQ)");
  end

  logic [1:0]            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] cmd_a_q, cmd_b_q;
  logic [3:0]            cmd_fun_q;
  logic [ID_W-1:0]       cmd_id_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_carry_q, resp_flag_q;
  logic [ID_W-1:0]       resp_id_q;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  any_req;
  logic                  accept, last_cnt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_carry, sel_flag;

  rr_grant #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr_grant (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  assign accept   = (state_q == ST_IDLE) && any_req;
  assign last_cnt = (state_q == ST_EXEC) && (cnt_q == CNT_W'(ALU_LAT - 1));
  assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)    state_d = ST_EXEC;
      ST_EXEC: if (last_cnt)   state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = (state_q == ST_IDLE) ? gnt : '0;
    resp_valid = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
  end

  // Unit select; carry is only meaningful for the arithmetic unit.
  always_comb begin
    sel_data  = arith_out;
    sel_flag  = arith_flag;
    sel_carry = carry_in;
    case (cmd_fun_q[3:2])
      SEL_LOGIC: begin sel_data = logic_out; sel_flag = logic_flag; sel_carry = 1'b0; end
      SEL_CMP:   begin sel_data = cmp_out;   sel_flag = cmp_flag;   sel_carry = 1'b0; end
      SEL_SHIFT: begin sel_data = shift_out; sel_flag = shift_flag; sel_carry = 1'b0; end
      default:   ;
    endcase
  end

  // Command and response registers. Command registers only change on an accept,
  // so the ALU inputs stay put for the whole EXEC/RESP window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      cmd_a_q      <= '0;
      cmd_b_q      <= '0;
      cmd_fun_q    <= '0;
      cmd_id_q     <= '0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
      resp_flag_q  <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      if (accept) begin
        cmd_a_q   <= req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        cmd_b_q   <= req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        cmd_fun_q <= req_fun[int'(gnt_idx)*4 +: 4];
        cmd_id_q  <= gnt_idx;
        rr_ptr_q  <= rr_ptr_d;
      end
      if (state_q == ST_EXEC) begin
        cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
      end
      if (last_cnt) begin
        resp_data_q  <= sel_data;
        resp_carry_q <= sel_carry;
        resp_flag_q  <= sel_flag;
        resp_id_q    <= cmd_id_q;
      end
    end
  end

  assign alu_a      = cmd_a_q;
  assign alu_b      = cmd_b_q;
  assign alu_fun    = cmd_fun_q;
  assign resp_data  = resp_data_q;
  assign resp_carry = resp_carry_q;
  assign resp_flag  = resp_flag_q;
  assign resp_id    = resp_id_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] op_count_q, stall_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_count_q    <= '0;
      stall_count_q <= '0;
    end else if (state_q == ST_RESP) begin
      if (resp_ready && op_count_q != 16'hFFFF)     op_count_q    <= op_count_q + 1'b1;
      if (!resp_ready && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: vector table, hand sequences, randomized ops.
// Latency: n/a.
// Backpressure: resp_ready driven by the bench, including multi-cycle stalls.
module tb_alu_req_arbiter;
  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic CLK = 1'b0;
  logic RST;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR*4-1:0]  req_fun;
  logic [DW-1:0]    alu_a, alu_b;
  logic [3:0]       alu_fun;
  logic [DW-1:0]    arith_out, logic_out, cmp_out, shift_out;
  logic             carry_in, arith_flag, logic_flag, cmp_flag, shift_flag;
  logic             resp_valid, resp_ready;
  logic [DW-1:0]    resp_data;
  logic             resp_carry, resp_flag;
  logic [IDW-1:0]   resp_id;
  logic             busy;
`ifdef ALU_ARB_PERF_EN
  logic [15:0]      op_count, stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  alu_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ALU_LAT(LAT), .ID_W(IDW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .carry_in(carry_in), .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_carry(resp_carry), .resp_flag(resp_flag), .resp_id(resp_id),
`ifdef ALU_ARB_PERF_EN
    .op_count(op_count), .stall_count(stall_count),
`endif
    .busy(busy)
  );

  // ALU stand-in: outputs follow the held ALU inputs.
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    arith_out  = alu_sum[DW-1:0];
    carry_in   = alu_sum[DW];
    arith_flag = (alu_sum[DW-1:0] == '0);
    logic_out  = alu_a ^ alu_b;
    logic_flag = ^(alu_a ^ alu_b);
    cmp_out    = DW'(alu_a < alu_b);
    cmp_flag   = (alu_a == alu_b);
    shift_out  = alu_a << 1;
    shift_flag = alu_a[DW-1];
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          c;
    logic          f;
  } res_t;

  // Expected response for a request: what the stand-in unit produces, picked by fun[3:2].
  function automatic res_t ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f);
    res_t r;
    int   s;
    s   = int'(a) + int'(b);
    r.c = 1'b0;
    case (f[3:2])
      2'b00:   begin r.d = DW'(s); r.c = (s > 255); r.f = (DW'(s) == 0); end
      2'b01:   begin r.d = a ^ b; r.f = ^(a ^ b); end
      2'b10:   begin r.d = DW'(a < b); r.f = (a == b); end
      default: begin r.d = a << 1; r.f = a[DW-1]; end
    endcase
    return r;
  endfunction

  typedef struct {
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    fun;
    logic [DW-1:0] d;
    logic          c;
    logic          f;
    int            stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] f);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    req_fun[idx*4 +: 4] = f;
  endtask

  task automatic garble();
    req_valid = '0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_fun   = 16'($urandom);
  endtask

  // Waits for a grant; returns just after the accepting edge.
  task automatic wait_accept(output logic [NR-1:0] rdy);
    rdy = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req_ready != '0) begin rdy = req_ready; break; end
      @(posedge CLK); #1;
    end
    if (rdy == '0) chk("accept_timeout", 0, 1);
    @(posedge CLK); #1;
  endtask

  // Called just after the accepting edge. Stalls 'stall' RESP cycles, then handshakes.
  task automatic wait_resp(input int stall, output int lat, output res_t r, output logic [IDW-1:0] id);
    logic got;
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (resp_valid) begin got = 1'b1; break; end
      lat++;
      @(posedge CLK); #1;
    end
    if (!got) chk("resp_timeout", 0, 1);
    r.d = resp_data; r.c = resp_carry; r.f = resp_flag; id = resp_id;
    for (int s = 0; s < stall; s++) begin
      req_valid = '1;  // competing requests must not be granted while RESP is held
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("stall_valid", 32'(resp_valid), 1);
      chk("stall_data", 32'(resp_data), 32'(r.d));
      chk("stall_id", 32'(resp_id), 32'(id));
      chk("stall_flag", 32'(resp_flag), 32'(r.f));
      chk("stall_req_ready", 32'(req_ready), 0);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t             vec[9];
    logic [NR-1:0]    rdy;
    int               lat;
    res_t             r, e;
    logic [IDW-1:0]   id;
    int               ptr, g, last_acc;
    logic [NR-1:0]    mask;
    logic [DW-1:0]    ra[NR], rb[NR];
    logic [3:0]       rf[NR];

    vec[0] = '{0, 8'h05, 8'h03, 4'b0000, 8'h08, 1'b0, 1'b0, 0};
    vec[1] = '{1, 8'hFF, 8'h01, 4'b0010, 8'h00, 1'b1, 1'b1, 0};
    vec[2] = '{2, 8'h3C, 8'h0F, 4'b0100, 8'h33, 1'b0, 1'b0, 5};
    vec[3] = '{3, 8'h10, 8'h20, 4'b1000, 8'h01, 1'b0, 1'b0, 0};
    vec[4] = '{0, 8'h77, 8'h77, 4'b1011, 8'h00, 1'b0, 1'b1, 1};
    vec[5] = '{1, 8'h78, 8'hFF, 4'b1101, 8'hF0, 1'b0, 1'b0, 0};
    vec[6] = '{2, 8'h81, 8'h00, 4'b1111, 8'h02, 1'b0, 1'b1, 0};
    vec[7] = '{3, 8'h80, 8'h80, 4'b0111, 8'h00, 1'b0, 1'b0, 2};
    vec[8] = '{0, 8'h80, 8'h80, 4'b0001, 8'h00, 1'b1, 1'b1, 0};

    RST = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_fun = '0; resp_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu", {alu_a, alu_b, alu_fun}, 0);
    chk("rst_resp", {resp_data, resp_carry, resp_flag, resp_id}, 0);
    @(posedge CLK); #1;

    // Vector table: one requester at a time, some with response backpressure.
    foreach (vec[i]) begin
      req_valid = '0;
      req_valid[vec[i].idx] = 1'b1;
      set_req(vec[i].idx, vec[i].a, vec[i].b, vec[i].fun);
      wait_accept(rdy);
      chk($sformatf("v%0d_req_ready", i), 32'(rdy), 32'(1) << vec[i].idx);
      garble();
      wait_resp(vec[i].stall, lat, r, id);
      chk($sformatf("v%0d_latency", i), 32'(lat), LAT + 1);
      chk($sformatf("v%0d_data", i), 32'(r.d), 32'(vec[i].d));
      chk($sformatf("v%0d_carry", i), 32'(r.c), 32'(vec[i].c));
      chk($sformatf("v%0d_flag", i), 32'(r.f), 32'(vec[i].f));
      chk($sformatf("v%0d_id", i), 32'(id), 32'(vec[i].idx));
    end

    // Reset mid-EXEC: the op from req1 is dropped and the pointer returns to 0.
    req_valid = 4'b0010;
    set_req(1, 8'h11, 8'h22, 4'b0000);
    wait_accept(rdy);
    garble();
    pulse_reset();
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge CLK);
      chk("rstx_resp_valid", 32'(resp_valid), 0);
      chk("rstx_busy", 32'(busy), 0);
      chk("rstx_outs", {alu_a, alu_b, alu_fun, resp_data, resp_carry, resp_flag, resp_id}, 0);
      @(posedge CLK); #1;
    end
    req_valid = 4'b0101;
    set_req(0, 8'h01, 8'h02, 4'b0000);
    set_req(2, 8'h09, 8'h09, 4'b1000);
    wait_accept(rdy);
    chk("rstx_ptr_grant", 32'(rdy), 32'h1);
    garble();
    wait_resp(0, lat, r, id);
    chk("rstx_ptr_id", 32'(id), 0);
    req_valid = 4'b0100;
    set_req(2, 8'h09, 8'h09, 4'b1000);
    wait_accept(rdy);
    chk("rstx_req2_grant", 32'(rdy), 32'h4);
    garble();
    wait_resp(0, lat, r, id);
    chk("rstx_req2_id", 32'(id), 2);
    chk("rstx_req2_data", 32'(r.d), 0);
    chk("rstx_req2_flag", 32'(r.f), 1);

    // Fairness: all requesters held valid, consumer always ready.
    pulse_reset();
    req_valid = '1;
    for (int q = 0; q < NR; q++) set_req(q, DW'(q), 8'h01, 4'b0000);
    resp_ready = 1'b1;
    last_acc = 0;
    for (int k = 0; k < 8; k++) begin
      wait_accept(rdy);
      chk($sformatf("fair%0d_grant", k), 32'(rdy), 32'(1) << (k % NR));
      if (k > 0) chk($sformatf("fair%0d_spacing", k), 32'(cyc - last_acc), LAT + 2);
      last_acc = cyc;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (resp_valid) break;
        @(posedge CLK); #1;
      end
      chk($sformatf("fair%0d_id", k), 32'(resp_id), 32'(k % NR));
      chk($sformatf("fair%0d_data", k), 32'(resp_data), 32'(k % NR) + 1);
      @(posedge CLK); #1;
    end
    req_valid = '0;
    resp_ready = 1'b0;
    @(posedge CLK); #1;

    // Randomized ops against the reference model.
    pulse_reset();
    ptr = 0;
    for (int n = 0; n < 60; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int q = 0; q < NR; q++) begin
        ra[q] = 8'($urandom); rb[q] = 8'($urandom); rf[q] = 4'($urandom);
        set_req(q, ra[q], rb[q], rf[q]);
      end
      req_valid = mask;
      g = -1;
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && mask[(ptr + k) % NR]) g = (ptr + k) % NR;
      end
      wait_accept(rdy);
      chk($sformatf("rnd%0d_grant", n), 32'(rdy), 32'(1) << g);
      ptr = (g + 1) % NR;
      e = ref_op(ra[g], rb[g], rf[g]);
      garble();
      wait_resp(int'($urandom_range(0, 2)), lat, r, id);
      chk($sformatf("rnd%0d_latency", n), 32'(lat), LAT + 1);
      chk($sformatf("rnd%0d_result", n), {r.d, r.c, r.f}, {e.d, e.c, e.f});
      chk($sformatf("rnd%0d_id", n), 32'(id), 32'(g));
    end

`ifdef ALU_ARB_PERF_EN
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001;
      set_req(0, 8'h01, 8'h01, 4'b0000);
      wait_accept(rdy);
      garble();
      wait_resp((k == 2) ? 0 : 1, lat, r, id);
    end
    @(negedge CLK);
    chk("perf_op_count", 32'(op_count), 3);
    chk("perf_stall_count", 32'(stall_count), 2);
    @(posedge CLK); #1;
    pulse_reset();
    @(negedge CLK);
    chk("perf_rst", {op_count, stall_count}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU_TOP instance between NUM_REQ requesters. Each requester has a valid/ready request channel carrying operands and ALU_FUN.
- Requesters are granted round-robin. The arbiter drives the ALU, waits ALU_LAT cycles for the registered unit outputs, and selects the active unit's result and flag by ALU_FUN[3:2].
- The result is returned on a single valid/ready response channel tagged with the requester ID.
- Sits between the command sources and ALU_TOP.

Parameters:
- DATA_WIDTH, 8, operand/result width; must match ALU_TOP.
- NUM_REQ, 4, number of requesters, 2..8.
- ALU_LAT, 1, cycles from ALU inputs applied to result valid at ALU outputs, 1..3.
- ID_W, 2, width of resp_id; equals clog2(NUM_REQ), localparam-checked.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept pulse, asserted in IDLE for the granted requester only.
- req_a  in  NUM_REQ*DATA_WIDTH  packed operand A; requester i occupies slice i.
- req_b  in  NUM_REQ*DATA_WIDTH  packed operand B.
- req_fun  in  NUM_REQ*4  packed ALU_FUN.
- alu_a  out  DATA_WIDTH  to ALU_TOP A.
- alu_b  out  DATA_WIDTH  to ALU_TOP B.
- alu_fun  out  4  to ALU_TOP ALU_FUN.
- arith_out, logic_out, cmp_out, shift_out  in  DATA_WIDTH each  from ALU_TOP.
- carry_in  in  1  from ALU_TOP Carry_OUT.
- arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  from ALU_TOP.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_data  out  DATA_WIDTH  selected result.
- resp_carry  out  1  Carry_OUT when fun[3:2]==00, else 0.
- resp_flag  out  1  flag of the selected unit.
- resp_id  out  ID_W  index of the requester served.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first requester at or after rr_ptr, with wrap-around.
  - Assert req_ready[g] combinationally in the same cycle.
  - Latch A, B, FUN and ID into command registers.
  - Next state EXEC; rr_ptr <= g+1 mod NUM_REQ.
- EXEC:
  - alu_a, alu_b and alu_fun are driven from the command registers. They are held stable in every state; the ALU is never driven with a foreign requester's data mid-operation.
  - A wait counter counts ALU_LAT cycles. On the final count, capture the result into the response registers and go to RESP.
- Result select by fun[3:2]:
  - 00 arith, with resp_carry = carry_in.
  - 01 logic.
  - 10 cmp.
  - 11 shift.
- RESP:
  - resp_valid=1 and the response registers are stable until the handshake.
  - On resp_valid & resp_ready, go to IDLE.
  - A new grant is not made in the same cycle as the handshake, so minimum issue spacing is ALU_LAT+2 cycles.
- Requester handshake: a request transfers when req_valid[i] & req_ready[i]. Requester-side inputs are sampled only in that cycle.
- Simultaneous requests: exactly one grant per IDLE cycle, with no requester granted twice while another is pending.
- Unused alu_fun encodings are passed through; the selection rule still applies.
- Reset (any state, mid-operation included):
  - State IDLE, rr_ptr 0, wait counter 0.
  - req_ready 0, resp_valid 0.
  - resp_data, resp_carry, resp_flag, resp_id all 0.
  - alu_a, alu_b, alu_fun all 0; busy 0.
  - An in-flight operation is dropped with no response.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds output port op_count (16 bits), which increments on each response handshake and saturates at 0xFFFF.
  - Adds output port stall_count (16 bits), which increments each RESP cycle with resp_ready=0 and saturates.
  - Both reset to 0.
- Undefined: neither port nor the counter logic exists. Behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - unit-select constants SEL_ARITH=2'b00, SEL_LOGIC=2'b01, SEL_CMP=2'b10, SEL_SHIFT=2'b11.
- One sub-module: rr_grant, combinational round-robin picker. Inputs are the req vector and rr_ptr; outputs are a one-hot grant, its index, and any_req.

Test Plan:
- Single op: req0 A=8'h05 B=8'h03 fun=4'b0000 → ALU model returns 8'h08 → resp_data=8'h08, resp_id=0, resp_carry=0, resp_valid asserts ALU_LAT+1 cycles after the accept.
- Fairness: all 4 requesters valid continuously, resp_ready=1 → resp_id sequence 0,1,2,3,0,1; no requester is served twice in any 4 consecutive grants.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_data/resp_id/resp_flag stable; req_ready stays 0 for all requesters; handshake completes on the first resp_ready=1.
- Select and carry: fun=4'b1101 (shift), shift_out=8'hF0, carry_in=1 → resp_data=8'hF0, resp_carry=0, resp_flag=shift_flag.
- Reset mid-EXEC: assert RST one cycle → no resp_valid, all outputs 0, rr_ptr=0; the next request from req2 is served normally.
- ALU_ARB_PERF_EN: 3 completed ops with 2 stall cycles → op_count=3, stall_count=2; after reset both read 0.
